// File: rtl/gshare_predictor.sv
// gshare branch predictor: tagged BTB plus 2-bit PHT indexed by PC xor global history.
// Lookups use a speculative history; resolved updates use the architectural history.
module gshare_predictor #(
    parameter int ABITS = 10,
    parameter int HBITS = 8,
    parameter int LANES = 2
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    output logic                  ready_o,
    input  logic                  lookup_valid_i,
    input  logic [31:0]           lookup_pc_i,
    output logic                  pred_valid_o,
    output logic [LANES-1:0]      pred_taken_o,
    output logic [32*LANES-1:0]   pred_tgt_o,
    input  logic                  update_i,
    input  logic [31:0]           update_pc_i,
    input  logic [31:0]           update_tgt_i,
    input  logic                  update_taken_i,
    input  logic                  mispredict_i
);
    localparam int ENTRIES = 2 ** ABITS;
    localparam int TAGW    = 30 - ABITS;

    typedef enum logic {ST_INIT, ST_READY} state_e;

    function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic up);
        if (up) return (ctr == 2'd3) ? ctr : ctr + 2'd1;
        return (ctr == 2'd0) ? ctr : ctr - 2'd1;
    endfunction

    function automatic logic [HBITS-1:0] ghr_shift(input logic [HBITS-1:0] ghr, input logic bit_in);
        logic [HBITS:0] ext;
        ext = {ghr, bit_in};
        return ext[HBITS-1:0];
    endfunction

    state_e                r_state;
    logic [ABITS-1:0]      r_sweep;
    logic [HBITS-1:0]      r_spec_ghr;
    logic [HBITS-1:0]      r_arch_ghr;
    logic                  r_ready;
    logic                  r_pvld;
    logic [LANES-1:0]      r_ptaken;
    logic [32*LANES-1:0]   r_ptgt;

    logic                  r_btb_vld [ENTRIES];
    logic [TAGW-1:0]       r_btb_tag [ENTRIES];
    logic [31:0]           r_btb_tgt [ENTRIES];
    logic [1:0]            r_pht     [ENTRIES];

    logic                  w_rdy;
    logic                  w_upd;
    logic                  w_squash;
    logic                  w_lkp;
    logic [HBITS-1:0]      w_arch_next;
    logic [ABITS-1:0]      w_uidx;
    logic [ABITS-1:0]      w_upht;
    logic [TAGW-1:0]       w_utag;
    logic [LANES-1:0]      w_raw;
    logic [LANES-1:0]      w_first;
    logic [32*LANES-1:0]   w_tgt;
    logic                  w_unused_upc;

    assign w_rdy       = (r_state == ST_READY);
    assign w_upd       = w_rdy & update_i;
    assign w_squash    = w_upd & mispredict_i;
    assign w_lkp       = w_rdy & lookup_valid_i & ~w_squash;
    assign w_arch_next = ghr_shift(r_arch_ghr, update_taken_i);
    assign w_uidx      = update_pc_i[ABITS+1:2];
    assign w_upht      = w_uidx ^ ABITS'(r_arch_ghr);
    assign w_utag      = update_pc_i[31:ABITS+2];
    assign w_unused_upc = ^update_pc_i[1:0];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [31:0]      w_pc;
        logic [ABITS-1:0] w_bidx;
        logic [ABITS-1:0] w_pidx;
        logic             w_unused_lo;

        assign w_pc        = lookup_pc_i + 32'(4 * k);
        assign w_bidx      = w_pc[ABITS+1:2];
        assign w_pidx      = w_bidx ^ ABITS'(r_spec_ghr);
        assign w_unused_lo = ^w_pc[1:0];
        assign w_raw[k]    = r_btb_vld[w_bidx] && (r_btb_tag[w_bidx] == w_pc[31:ABITS+2])
                             && r_pht[w_pidx][1];
        assign w_tgt[32*k +: 32] = r_btb_tgt[w_bidx];
    end

    // Keep only the first predicted-taken lane: control leaves the group there.
    assign w_first = w_raw & (~w_raw + LANES'(1));

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= ST_INIT;
            r_sweep    <= '0;
            r_spec_ghr <= '0;
            r_arch_ghr <= '0;
            r_ready    <= 1'b0;
            r_pvld     <= 1'b0;
            r_ptaken   <= '0;
            r_ptgt     <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_sweep <= r_sweep + ABITS'(1);
                    if (r_sweep == ABITS'(ENTRIES - 1)) begin
                        r_state <= ST_READY;
                        r_ready <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (w_upd) r_arch_ghr <= w_arch_next;
                    // A mispredict resynchronises speculative history and drops the in-flight prediction.
                    if (w_squash)    r_spec_ghr <= w_arch_next;
                    else if (r_pvld) r_spec_ghr <= ghr_shift(r_spec_ghr, |r_ptaken);
                    r_pvld   <= w_lkp;
                    r_ptaken <= w_lkp ? w_first : '0;
                    if (w_lkp) r_ptgt <= w_tgt;
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    // Table storage: nonblocking writes give read-before-write on a same-cycle collision.
    always_ff @(posedge clock_i) begin
        if (r_state == ST_INIT) begin
            r_btb_vld[r_sweep] <= 1'b0;
            r_pht[r_sweep]     <= 2'd1;
        end else if (update_i) begin
            r_pht[w_upht] <= sat_ctr(r_pht[w_upht], update_taken_i);
            if (update_taken_i) begin
                r_btb_vld[w_uidx] <= 1'b1;
                r_btb_tag[w_uidx] <= w_utag;
                r_btb_tgt[w_uidx] <= update_tgt_i;
            end
        end
    end

    assign ready_o      = r_ready;
    assign pred_valid_o = r_pvld;
    assign pred_taken_o = r_ptaken;
    assign pred_tgt_o   = r_ptgt;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor (ABITS=4, HBITS=4, LANES=2) with a vector
// table for training/lane cases and hand-written multi-cycle sequences.
module tb_gshare_predictor;
    localparam int ABITS = 4;
    localparam int HBITS = 4;
    localparam int LANES = 2;
    localparam logic [63:0] M0 = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] M1 = 64'hFFFF_FFFF_0000_0000;

    logic                clk;
    logic                reset_i;
    logic                ready_o;
    logic                lookup_valid_i;
    logic [31:0]         lookup_pc_i;
    logic                pred_valid_o;
    logic [LANES-1:0]    pred_taken_o;
    logic [32*LANES-1:0] pred_tgt_o;
    logic                update_i;
    logic [31:0]         update_pc_i;
    logic [31:0]         update_tgt_i;
    logic                update_taken_i;
    logic                mispredict_i;

    int n_cmp  = 0;
    int n_fail = 0;

    gshare_predictor #(.ABITS(ABITS), .HBITS(HBITS), .LANES(LANES)) dut (
        .clock_i        (clk),
        .reset_i        (reset_i),
        .ready_o        (ready_o),
        .lookup_valid_i (lookup_valid_i),
        .lookup_pc_i    (lookup_pc_i),
        .pred_valid_o   (pred_valid_o),
        .pred_taken_o   (pred_taken_o),
        .pred_tgt_o     (pred_tgt_o),
        .update_i       (update_i),
        .update_pc_i    (update_pc_i),
        .update_tgt_i   (update_tgt_i),
        .update_taken_i (update_taken_i),
        .mispredict_i   (mispredict_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        upd;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        utk;
        logic        umis;
        logic        lkp;
        logic [31:0] lpc;
        logic        exp_vld;
        logic [1:0]  exp_tk;
        logic [63:0] exp_tgt;
        logic [63:0] tmask;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t v_none();
        vec_t v;
        v.rst = 1'b0; v.upd = 1'b0; v.upc = '0; v.utgt = '0; v.utk = 1'b0; v.umis = 1'b0;
        v.lkp = 1'b0; v.lpc = '0; v.exp_vld = 1'b0; v.exp_tk = '0; v.exp_tgt = '0; v.tmask = '0;
        return v;
    endfunction

    function automatic vec_t v_rst();
        vec_t v;
        v = v_none();
        v.rst = 1'b1;
        return v;
    endfunction

    function automatic vec_t v_upd(input logic [31:0] pc, input logic [31:0] tgt,
                                   input logic tk, input logic mis);
        vec_t v;
        v = v_none();
        v.upd = 1'b1; v.upc = pc; v.utgt = tgt; v.utk = tk; v.umis = mis;
        return v;
    endfunction

    function automatic vec_t v_lkp(input logic [31:0] pc, input logic [1:0] etk,
                                   input logic [63:0] etgt, input logic [63:0] mask);
        vec_t v;
        v = v_none();
        v.lkp = 1'b1; v.lpc = pc; v.exp_vld = 1'b1; v.exp_tk = etk; v.exp_tgt = etgt; v.tmask = mask;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        update_i       = v.upd;
        update_pc_i    = v.upc;
        update_tgt_i   = v.utgt;
        update_taken_i = v.utk;
        mispredict_i   = v.umis;
        lookup_valid_i = v.lkp;
        lookup_pc_i    = v.lpc;
        @(posedge clk); #1;
        update_i       = 1'b0;
        mispredict_i   = 1'b0;
        lookup_valid_i = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        int   n;
        logic saw_pv;
        reset_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_rst_ready"}, 64'(ready_o), 64'd0);
        chk({tag, "_rst_pvld"}, 64'(pred_valid_o), 64'd0);
        reset_i = 1'b0;
        n = 0;
        saw_pv = 1'b0;
        while (!ready_o && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (pred_valid_o) saw_pv = 1'b1;
        end
        chk({tag, "_ready_latency"}, 64'(n), 64'd16);
        chk({tag, "_init_pvld"}, 64'(saw_pv), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1; lookup_valid_i = 1'b0; lookup_pc_i = '0;
        update_i = 1'b0; update_pc_i = '0; update_tgt_i = '0;
        update_taken_i = 1'b0; mispredict_i = 1'b0;

        tv.push_back(v_lkp(32'h0000_0000, 2'b00, 64'd0, 64'd0));
        tv.push_back(v_lkp(32'h0000_0040, 2'b00, 64'd0, 64'd0));
        tv.push_back(v_upd(32'h0000_0040, 32'h0000_0200, 1'b1, 1'b0));
        tv.push_back(v_upd(32'h0000_0040, 32'h0000_0200, 1'b1, 1'b0));
        tv.push_back(v_lkp(32'h0000_0040, 2'b01, 64'h0000_0000_0000_0200, M0));
        tv.push_back(v_rst());
        tv.push_back(v_upd(32'h0000_0100, 32'h0000_0500, 1'b1, 1'b0));
        tv.push_back(v_upd(32'h0000_0100, 32'h0000_0500, 1'b1, 1'b0));
        tv.push_back(v_upd(32'h0000_0104, 32'h0000_0600, 1'b1, 1'b0));
        tv.push_back(v_lkp(32'h0000_0100, 2'b01, 64'h0000_0600_0000_0500, M0 | M1));
        tv.push_back(v_lkp(32'h0000_0104, 2'b01, 64'h0000_0000_0000_0600, M0));
        tv.push_back(v_lkp(32'h0000_00FC, 2'b10, 64'h0000_0500_0000_0000, M1));
        tv.push_back(v_lkp(32'h0000_0140, 2'b00, 64'd0, 64'd0));
        tv.push_back(v_none());

        #1;
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_pvld", 64'(pred_valid_o), 64'd0);
        chk("reset_ptaken", 64'(pred_taken_o), 64'd0);
        chk("reset_ptgt", 64'(pred_tgt_o), 64'd0);

        // Lookups and updates presented throughout INIT must be ignored.
        lookup_valid_i = 1'b1; lookup_pc_i = 32'h40;
        update_i = 1'b1; update_pc_i = 32'h40; update_tgt_i = 32'h200; update_taken_i = 1'b1;
        do_reset("init");
        lookup_valid_i = 1'b0; update_i = 1'b0; update_taken_i = 1'b0;
        chk("init_arch_ghr", 64'(dut.r_arch_ghr), 64'd0);

        foreach (tv[i]) begin
            if (tv[i].rst) begin
                do_reset($sformatf("tv%0d", i));
            end else begin
                step(tv[i]);
                chk($sformatf("tv%0d_pvld", i), 64'(pred_valid_o), 64'(tv[i].exp_vld));
                if (tv[i].exp_vld) begin
                    chk($sformatf("tv%0d_ptaken", i), 64'(pred_taken_o), 64'(tv[i].exp_tk));
                    if (tv[i].tmask != 64'd0)
                        chk($sformatf("tv%0d_ptgt", i), 64'(pred_tgt_o) & tv[i].tmask,
                            tv[i].exp_tgt & tv[i].tmask);
                end
            end
        end

        // Saturation: warm arch history to 0xF, then hammer PHT[0x80 idx ^ 0xF].
        do_reset("sat");
        repeat (4) step(v_upd(32'h10, 32'h50, 1'b1, 1'b0));
        repeat (4) step(v_upd(32'h80, 32'h300, 1'b1, 1'b0));
        step(v_upd(32'h80, 32'h300, 1'b1, 1'b1));
        step(v_upd(32'h80, 32'h300, 1'b0, 1'b0));
        chk("sat_counter", 64'(dut.r_pht[15]), 64'd2);
        chk("sat_spec_ghr", 64'(dut.r_spec_ghr), 64'hF);
        chk("sat_arch_ghr", 64'(dut.r_arch_ghr), 64'hE);
        step(v_lkp(32'h80, 2'b01, 64'h300, M0));
        chk("sat_pvld", 64'(pred_valid_o), 64'd1);
        chk("sat_ptaken", 64'(pred_taken_o), 64'd1);
        chk("sat_ptgt0", 64'(pred_tgt_o) & M0, 64'h300);

        // Mispredict recovery with arch history 0x05.
        do_reset("mis");
        step(v_upd(32'h200, 32'h240, 1'b1, 1'b0));
        step(v_upd(32'h200, 32'h240, 1'b0, 1'b0));
        chk("mis_dec_counter", 64'(dut.r_pht[1]), 64'd0);
        step(v_upd(32'h200, 32'h240, 1'b1, 1'b0));
        chk("mis_arch_pre", 64'(dut.r_arch_ghr), 64'h5);
        step(v_lkp(32'h200, 2'b01, 64'h240, M0));
        chk("mis_pre_pvld", 64'(pred_valid_o), 64'd1);
        chk("mis_pre_ptaken", 64'(pred_taken_o), 64'd1);
        begin
            vec_t v;
            v = v_upd(32'h300, 32'h340, 1'b1, 1'b1);
            v.lkp = 1'b1; v.lpc = 32'h200;
            step(v);
        end
        chk("mis_squash_pvld", 64'(pred_valid_o), 64'd0);
        chk("mis_spec_ghr", 64'(dut.r_spec_ghr), 64'hB);
        chk("mis_arch_ghr", 64'(dut.r_arch_ghr), 64'hB);
        step(v_lkp(32'h300, 2'b00, 64'd0, 64'd0));
        chk("mis_post_pvld", 64'(pred_valid_o), 64'd1);
        chk("mis_post_ptaken", 64'(pred_taken_o), 64'd0);

        // Same-entry lookup and update in one cycle: the lookup sees the old counter.
        begin
            vec_t v;
            v = v_upd(32'h300, 32'h340, 1'b1, 1'b0);
            v.lkp = 1'b1; v.lpc = 32'h300;
            step(v);
        end
        chk("rbw_pvld", 64'(pred_valid_o), 64'd1);
        chk("rbw_ptaken", 64'(pred_taken_o), 64'd0);
        chk("rbw_counter_written", 64'(dut.r_pht[11]), 64'd2);

        // Asynchronous reset clears outputs without a clock edge.
        #2 reset_i = 1'b1;
        #1;
        chk("async_pvld", 64'(pred_valid_o), 64'd0);
        chk("async_ready", 64'(ready_o), 64'd0);
        chk("async_ptgt", 64'(pred_tgt_o), 64'd0);
        do_reset("post_async");

        // Reset pulsed in the middle of the INIT sweep.
        reset_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("midinit_sweep", 64'(dut.r_sweep), 64'd7);
        chk("midinit_ready", 64'(ready_o), 64'd0);
        do_reset("midinit");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
